rect_motion_ctl: RTL and testbench

Frame-synchronous motion controller for the on-screen rectangle (player sprite) drawn by the rectangle overlay stage of the VGA pipeline. It produces the overlay's `xpos`, `ypos` and `module_en`. It runs a jump/fall state machine with per-frame velocity, and applies horizontal steering with edge clamping. All position changes are committed once per frame, at the rising edge of `vsync_in`, so a rectangle is never torn mid-frame.

---
 rtl/rect_motion_ctl_if.sv | 34 +++
 rtl/rect_motion_ctl.sv | 193 +++++++++++++++++++
 tb/tb_rect_motion_ctl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rect_motion_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module      : rect_motion_ctl_if
//  Description : Signal bundle between the rectangle motion controller and its
//                environment. It carries the frame sync, the control pulses, the
//                steering levels and the registered sprite position/enable.
//                  master : drives vsync_in/start/stop/jump/left/right,
//                           observes xpos/ypos/module_en/airborne
//                  slave  : the controller side
//  Revision    : 1.0  initial release
// ============================================================================
interface rect_motion_ctl_if;
  logic       vsync_in;
  logic       start;
  logic       stop;
  logic       jump;
  logic       left;
  logic       right;
  logic [8:0] xpos;
  logic [8:0] ypos;
  logic       module_en;
  logic       airborne;

  modport master (
    output vsync_in, start, stop, jump, left, right,
    input  xpos, ypos, module_en, airborne
  );

  modport slave (
    input  vsync_in, start, stop, jump, left, right,
    output xpos, ypos, module_en, airborne
  );
endinterface
`default_nettype wire

// File: rtl/rect_motion_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : rect_motion_ctl
//  Description : Frame-synchronous motion controller for the overlay rectangle.
//                Jump/fall state machine with per-frame velocity plus clamped
//                horizontal steering. Position updates are committed only on
//                the rising edge of vsync_in so a frame is never torn.
//  Ports       : pclk  - pixel clock
//                rst   - synchronous active-high reset
//                bus   - rect_motion_ctl_if.slave (vsync_in, start, stop, jump,
//                        left, right in; xpos, ypos, module_en, airborne out)
//  Revision    : 1.0  initial release
// ============================================================================
module rect_motion_ctl #(
  parameter int X_INIT       = 200,
  parameter int Y_GROUND     = 400,
  parameter int X_MAX        = 432,
  parameter int X_STEP       = 4,
  parameter int JUMP_VEL     = 12,
  parameter int FALL_VEL_MAX = 12
) (
  input logic              pclk,
  input logic              rst,
  rect_motion_ctl_if.slave bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_STAND = 2'd1;
  localparam logic [1:0] c_RISE  = 2'd2;
  localparam logic [1:0] c_FALL  = 2'd3;

  localparam logic [9:0] c_X_INIT   = 10'(X_INIT);
  localparam logic [9:0] c_Y_GROUND = 10'(Y_GROUND);
  localparam logic [9:0] c_X_MAX    = 10'(X_MAX);
  localparam logic [9:0] c_X_STEP   = 10'(X_STEP);
  localparam logic [4:0] c_JUMP_VEL = 5'(JUMP_VEL);
  localparam logic [4:0] c_FALL_MAX = 5'(FALL_VEL_MAX);

  logic [1:0] r_state;
  logic [4:0] r_vel;
  logic [8:0] r_xpos;
  logic [8:0] r_ypos;
  logic       r_module_en;
  logic       r_airborne;
  logic       r_jump_req;
  logic       r_vsync_d;

  logic [1:0] w_state_nxt;
  logic [4:0] w_vel_nxt;
  logic [9:0] w_x_nxt;
  logic [9:0] w_y_nxt;
  logic       w_jump_req_nxt;
  logic       w_module_en_nxt;
  logic       w_airborne_nxt;

  logic       w_tick;
  logic       w_jump_eff;
  logic [9:0] w_x10;
  logic [9:0] w_y10;
  logic [9:0] w_x_left;
  logic [9:0] w_x_right_raw;
  logic [9:0] w_x_right;
  logic [9:0] w_x_steer;
  logic       w_rise_sat;
  logic [9:0] w_y_rise;
  logic [4:0] w_vel_dec;
  logic [5:0] w_vel_inc;
  logic [4:0] w_vel_fall;
  logic [9:0] w_y_fall;
  logic       w_land;
  logic       w_unused;

  assign w_tick     = bus.vsync_in & ~r_vsync_d;
  // A jump arriving in the tick cycle itself still counts for that tick.
  assign w_jump_eff = r_jump_req | bus.jump;

  // All arithmetic carries one headroom bit so clamps see the true result.
  assign w_x10         = {1'b0, r_xpos};
  assign w_y10         = {1'b0, r_ypos};
  assign w_x_left      = (w_x10 < c_X_STEP) ? 10'd0 : (w_x10 - c_X_STEP);
  assign w_x_right_raw = w_x10 + c_X_STEP;
  assign w_x_right     = (w_x_right_raw > c_X_MAX) ? c_X_MAX : w_x_right_raw;
  assign w_x_steer     = (bus.left & ~bus.right) ? w_x_left  :
                         (bus.right & ~bus.left) ? w_x_right : w_x10;

  assign w_rise_sat = (w_y10 < {5'd0, r_vel});
  assign w_y_rise   = w_rise_sat ? 10'd0 : (w_y10 - {5'd0, r_vel});
  assign w_vel_dec  = r_vel - 5'd1;

  assign w_vel_inc  = {1'b0, r_vel} + 6'd1;
  assign w_vel_fall = (w_vel_inc > {1'b0, c_FALL_MAX}) ? c_FALL_MAX : w_vel_inc[4:0];
  assign w_y_fall   = w_y10 + {5'd0, w_vel_fall};
  assign w_land     = (w_y_fall >= c_Y_GROUND);

  // Next-state / next-datapath logic.
  always_comb begin : p_next
    w_state_nxt    = r_state;
    w_vel_nxt      = r_vel;
    w_x_nxt        = w_x10;
    w_y_nxt        = w_y10;
    w_jump_req_nxt = r_jump_req;

    // The request is dropped at every tick, consumed or not.
    if (w_tick) begin
      w_jump_req_nxt = 1'b0;
    end else if (bus.jump) begin
      w_jump_req_nxt = 1'b1;
    end

    if (bus.stop) begin
      // Positions intentionally hold their last values.
      w_state_nxt = c_IDLE;
    end else if (bus.start) begin
      // Also acts as a respawn when already running.
      w_state_nxt    = c_STAND;
      w_x_nxt        = c_X_INIT;
      w_y_nxt        = c_Y_GROUND;
      w_vel_nxt      = 5'd0;
      w_jump_req_nxt = 1'b0;
    end else if (w_tick) begin
      case (r_state)
        c_STAND: begin
          w_x_nxt = w_x_steer;
          if (w_jump_eff) begin
            w_state_nxt = c_RISE;
            w_vel_nxt   = c_JUMP_VEL;
          end
        end
        c_RISE: begin
          w_x_nxt = w_x_steer;
          w_y_nxt = w_y_rise;
          // Hitting the top edge kills the remaining upward velocity.
          if (w_rise_sat || (w_vel_dec == 5'd0)) begin
            w_state_nxt = c_FALL;
            w_vel_nxt   = 5'd0;
          end else begin
            w_vel_nxt   = w_vel_dec;
          end
        end
        c_FALL: begin
          w_x_nxt = w_x_steer;
          if (w_land) begin
            w_state_nxt = c_STAND;
            w_y_nxt     = c_Y_GROUND;
            w_vel_nxt   = 5'd0;
          end else begin
            w_y_nxt     = w_y_fall;
            w_vel_nxt   = w_vel_fall;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from the next state, so the flags are registered alongside it.
  always_comb begin : p_out
    w_module_en_nxt = (w_state_nxt != c_IDLE);
    w_airborne_nxt  = (w_state_nxt == c_RISE) || (w_state_nxt == c_FALL);
  end

  always_ff @(posedge pclk) begin : p_reg
    if (rst) begin
      r_state     <= c_IDLE;
      r_vel       <= 5'd0;
      r_xpos      <= c_X_INIT[8:0];
      r_ypos      <= c_Y_GROUND[8:0];
      r_module_en <= 1'b0;
      r_airborne  <= 1'b0;
      r_jump_req  <= 1'b0;
      r_vsync_d   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_vel       <= w_vel_nxt;
      r_xpos      <= w_x_nxt[8:0];
      r_ypos      <= w_y_nxt[8:0];
      r_module_en <= w_module_en_nxt;
      r_airborne  <= w_airborne_nxt;
      r_jump_req  <= w_jump_req_nxt;
      r_vsync_d   <= bus.vsync_in;
    end
  end

  // Headroom bits are always zero after clamping.
  assign w_unused = ^{w_x_nxt[9], w_y_nxt[9]};

  assign bus.xpos      = r_xpos;
  assign bus.ypos      = r_ypos;
  assign bus.module_en = r_module_en;
  assign bus.airborne  = r_airborne;

endmodule
`default_nettype wire

// File: tb/tb_rect_motion_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rect_motion_ctl
//  Description : Bench for rect_motion_ctl. The driver issues directed frames
//                and control pulses and queues the expected outputs; the monitor
//                compares on every frame tick and on explicit check requests.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rect_motion_ctl;

  typedef struct {
    logic [8:0] x;
    logic [8:0] y;
    logic       en;
    logic       air;
    string      name;
  } exp_t;

  logic pclk;
  logic rst;
  rect_motion_ctl_if bus ();

  rect_motion_ctl dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  exp_t q[$];
  int   n_cmp;
  int   n_err;
  logic chk_now;
  logic done;
  logic done_seen;
  logic pend;
  logic vs_prev;

  // Hand-derived y sequence of one full jump, starting at the jump tick.
  int jy[25] = '{400, 388, 377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322,
                 323, 325, 328, 332, 337, 343, 350, 358, 367, 377, 388, 400};

  function automatic bit outputs_match(exp_t e);
    return (bus.xpos == e.x) && (bus.ypos == e.y) &&
           (bus.module_en == e.en) && (bus.airborne == e.air);
  endfunction

  // Monitor: a tick seen at this negedge is compared at the next one,
  // after the DUT has committed the frame update.
  always @(negedge pclk) begin
    vs_prev <= bus.vsync_in;
    pend    <= !rst && bus.vsync_in && !vs_prev;
    if (pend || chk_now) begin
      n_cmp <= n_cmp + 1;
      if (q.size() == 0) begin
        n_err <= n_err + 1;
        $display("FAIL unexpected_output: got x=%0d y=%0d en=%0b air=%0b with nothing queued",
                 bus.xpos, bus.ypos, bus.module_en, bus.airborne);
      end else begin
        if (!outputs_match(q[0])) begin
          n_err <= n_err + 1;
          $display("FAIL %s: got x=%0d y=%0d en=%0b air=%0b, want x=%0d y=%0d en=%0b air=%0b",
                   q[0].name, bus.xpos, bus.ypos, bus.module_en, bus.airborne,
                   q[0].x, q[0].y, q[0].en, q[0].air);
        end
        void'(q.pop_front());
      end
    end
    if (done && !done_seen) begin
      done_seen <= 1'b1;
      if (q.size() != 0) begin
        n_cmp <= n_cmp + 1;
        n_err <= n_err + 1;
        $display("FAIL leftover: got %0d unchecked entries, want 0", q.size());
      end
    end
  end

  task automatic push(input int x, input int y, input bit en, input bit air, input string nm);
    exp_t e;
    e.x = 9'(x); e.y = 9'(y); e.en = en; e.air = air; e.name = nm;
    q.push_back(e);
  endtask

  task automatic check_now(input int x, input int y, input bit en, input bit air, input string nm);
    push(x, y, en, air, nm);
    chk_now = 1'b1;
    @(negedge pclk);
    #1;
    chk_now = 1'b0;
    @(posedge pclk);
    #1;
  endtask

  task automatic frame(input int x, input int y, input bit en, input bit air, input string nm);
    push(x, y, en, air, nm);
    @(posedge pclk);
    #1;
    bus.vsync_in = 1'b1;
    repeat (2) begin @(posedge pclk); #1; end
    bus.vsync_in = 1'b0;
    repeat (2) begin @(posedge pclk); #1; end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; @(posedge pclk); #1; bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1; @(posedge pclk); #1; bus.stop = 1'b0;
  endtask

  task automatic pulse_jump();
    bus.jump = 1'b1; @(posedge pclk); #1; bus.jump = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test within time limit, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    chk_now = 0; done = 0; done_seen = 0; pend = 0; vs_prev = 0;
    bus.vsync_in = 0; bus.start = 0; bus.stop = 0;
    bus.jump = 0; bus.left = 0; bus.right = 0;
    rst = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    rst = 1'b0;

    check_now(200, 400, 0, 0, "reset_state");
    pulse_start();
    check_now(200, 400, 1, 0, "start_enable");
    for (int i = 0; i < 5; i++) frame(200, 400, 1, 0, "idle_frames");

    // Single jump pulse between ticks.
    pulse_jump();
    for (int i = 0; i < 25; i++) frame(200, jy[i], 1, (i < 24), "jump_pulse");

    // Steering to both clamps, then both keys held.
    bus.left = 1'b1;
    for (int k = 1; k <= 52; k++) frame((200 - 4*k > 0) ? 200 - 4*k : 0, 400, 1, 0, "steer_left");
    bus.left = 1'b0; bus.right = 1'b1;
    for (int k = 1; k <= 110; k++) frame((4*k < 432) ? 4*k : 432, 400, 1, 0, "steer_right");
    bus.left = 1'b1;
    for (int k = 0; k < 2; k++) frame(432, 400, 1, 0, "steer_both");
    bus.left = 1'b0; bus.right = 1'b0;

    // Jump held: no extension, re-jump on the first tick after landing.
    bus.jump = 1'b1;
    for (int i = 0; i < 25; i++) frame(432, jy[i], 1, (i < 24), "jump_held");
    frame(432, 400, 1, 1, "rejump_after_land");
    bus.jump = 1'b0;
    for (int i = 1; i <= 3; i++) frame(432, jy[i], 1, 1, "rejump_rise");

    // Stop mid-jump freezes positions; start respawns.
    pulse_stop();
    check_now(432, 367, 0, 0, "stop_midjump");
    for (int i = 0; i < 2; i++) frame(432, 367, 0, 0, "stopped_frozen");
    pulse_start();
    check_now(200, 400, 1, 0, "respawn");
    frame(200, 400, 1, 0, "respawn_stand");

    // Reset mid-fall with vsync held high across release.
    pulse_jump();
    for (int i = 0; i < 14; i++) frame(200, jy[i], 1, (i < 24), "jump_to_fall");
    rst = 1'b1; bus.vsync_in = 1'b1;
    repeat (2) begin @(posedge pclk); #1; end
    check_now(200, 400, 0, 0, "rst_midfall");
    rst = 1'b0;
    repeat (4) begin @(posedge pclk); #1; end
    check_now(200, 400, 0, 0, "vsync_high_release");
    bus.vsync_in = 1'b0;
    repeat (2) begin @(posedge pclk); #1; end
    pulse_start();
    check_now(200, 400, 1, 0, "start_after_rst");
    frame(200, 400, 1, 0, "no_residual_vel");

    done = 1'b1;
    repeat (4) @(posedge pclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
